pong_auto_player: RTL and testbench

Hardware opponent for the ping-pong game: watches the game's 8-bit ball LED bar and drives one player button the same way a human (or the bench) would. It returns the ball when it reaches its end, serves after a score display, and misses at a programmable rate. It sits beside the game core on the board top and replaces one physical button input (B_L or B_R). Selectable as left or right player.

---
 rtl/pong_pkg.sv | 26 ++
 rtl/pong_lfsr8.sv | 21 ++
 rtl/pong_auto_player.sv | 135 +++++++++++++
 tb/tb_pong_auto_player.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the ping-pong game core and the automatic player.
package pong_pkg;

  typedef enum logic [1:0] {
    WATCH    = 2'd0,
    DELAY    = 2'd1,
    PRESS    = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  typedef struct packed {
    state_t     fsm;
    logic [7:0] lfsr;
  } dbg_t;

  localparam logic [7:0] END_L = 8'h80;
  localparam logic [7:0] END_R = 8'h01;

  // Fibonacci taps 8,6,5,4 as a mask over state bits [7:0].
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/pong_lfsr8.sv
// 8-bit Fibonacci LFSR used as the miss-decision source; shifts toward the MSB.
module pong_lfsr8
  import pong_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[6:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/pong_auto_player.sv
// Automatic ping-pong opponent: returns arriving balls, serves after a stable
// score display, and misses at a programmable rate.
module pong_auto_player
  import pong_pkg::*;
#(
  parameter bit          SIDE        = 1'b0,
  parameter int unsigned REACT_DELAY = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned SERVE_IDLE  = 16,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       SERVE,
  input  logic [1:0] MISS_RATE,
  input  logic [7:0] LED,
  output logic       BTN,
  output logic [7:0] HIT_CNT,
  output logic [7:0] MISS_CNT,
  output dbg_t       DBG
);

  localparam logic [7:0]  END_MASK = SIDE ? END_L : END_R;
  localparam logic [7:0]  REACT    = 8'(REACT_DELAY);
  localparam logic [7:0]  HOLD     = 8'(HOLD_CYCLES);
  localparam logic [15:0] IDLE     = 16'(SERVE_IDLE);

  state_t      state, next_state;
  logic [7:0]  led_q;
  logic [7:0]  cnt, cnt_next;
  logic [15:0] idle_cnt, idle_next;
  logic [7:0]  lfsr;
  logic        at_end, arrival, miss, stable_idle;
  logic        hit_inc, miss_inc;

  pong_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk   (CLK),
    .rst   (RST),
    .en    (EN),
    .state (lfsr)
  );

  // An arrival needs the ball to have come from a real in-flight position,
  // so a jump from a blank or score pattern onto the end LED is ignored.
  assign at_end      = (LED == END_MASK);
  assign arrival     = at_end && (led_q != END_MASK) && is_onehot8(led_q);
  assign miss        = (lfsr[1:0] < MISS_RATE);
  assign stable_idle = !is_onehot8(LED) && (LED == led_q);

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    idle_next  = 16'd0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    case (state)
      WATCH: begin
        if (stable_idle) begin
          idle_next = (idle_cnt == IDLE) ? idle_cnt : idle_cnt + 16'd1;
        end
        if (arrival) begin
          idle_next = 16'd0;
          if (miss) begin
            next_state = COOLDOWN;
            miss_inc   = 1'b1;
          end else if (REACT == 8'd0) begin
            next_state = PRESS;
            cnt_next   = HOLD;
            hit_inc    = 1'b1;
          end else begin
            next_state = DELAY;
            cnt_next   = REACT;
          end
        end else if (SERVE && (idle_cnt == IDLE)) begin
          next_state = PRESS;
          cnt_next   = HOLD;
          idle_next  = 16'd0;
        end
      end
      DELAY: begin
        if (!at_end) begin
          next_state = COOLDOWN;
        end else if (cnt <= 8'd1) begin
          next_state = PRESS;
          cnt_next   = HOLD;
          hit_inc    = 1'b1;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      PRESS: begin
        if (cnt <= 8'd1) begin
          next_state = COOLDOWN;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      COOLDOWN: begin
        if (!at_end) next_state = WATCH;
      end
      default: next_state = WATCH;
    endcase
    if (!EN) begin
      next_state = WATCH;
      idle_next  = 16'd0;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= WATCH;
      led_q    <= 8'h00;
      cnt      <= 8'd0;
      idle_cnt <= 16'd0;
      BTN      <= 1'b0;
      HIT_CNT  <= 8'd0;
      MISS_CNT <= 8'd0;
    end else begin
      state    <= next_state;
      led_q    <= LED;
      cnt      <= cnt_next;
      idle_cnt <= idle_next;
      BTN      <= (next_state == PRESS);
      if (hit_inc && (HIT_CNT != 8'hFF))   HIT_CNT  <= HIT_CNT + 8'd1;
      if (miss_inc && (MISS_CNT != 8'hFF)) MISS_CNT <= MISS_CNT + 8'd1;
    end
  end

  assign DBG = '{fsm: state, lfsr: lfsr};

endmodule

// File: tb/tb_pong_auto_player.sv
// Bench for pong_auto_player: right and left instances against a cycle-window model.
module tb_pong_auto_player;
  import pong_pkg::*;

  localparam int R = 4;
  localparam int H = 2;
  localparam int IDLE = 16;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst, en, serve_r, serve_l;
  logic [1:0] miss_rate;
  logic [7:0] led_r, led_l;
  logic btn_r, btn_l;
  logic [7:0] hit_r, miss_r, hit_l, miss_l;
  dbg_t dbg_r, dbg_l;

  int checks = 0;
  int failures = 0;
  int exp_hit_r = 0, exp_miss_r = 0, exp_hit_l = 0;
  logic [7:0] m_lfsr;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pong_auto_player #(.SIDE(1'b0), .REACT_DELAY(R), .HOLD_CYCLES(H),
                     .SERVE_IDLE(IDLE), .SEED(SEED)) dut_r (
    .CLK(clk), .RST(rst), .EN(en), .SERVE(serve_r), .MISS_RATE(miss_rate),
    .LED(led_r), .BTN(btn_r), .HIT_CNT(hit_r), .MISS_CNT(miss_r), .DBG(dbg_r)
  );

  pong_auto_player #(.SIDE(1'b1), .REACT_DELAY(R), .HOLD_CYCLES(H),
                     .SERVE_IDLE(IDLE), .SEED(SEED)) dut_l (
    .CLK(clk), .RST(rst), .EN(en), .SERVE(serve_l), .MISS_RATE(miss_rate),
    .LED(led_l), .BTN(btn_l), .HIT_CNT(hit_l), .MISS_CNT(miss_l), .DBG(dbg_l)
  );

  // Reference random source: x^8+x^6+x^5+x^4 sequence, new bit enters at the LSB.
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else if (en) m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // One right-side arrival: approach 04,02,01, watch the button for R+H+2 cycles.
  task automatic arrive_r(input int gap, input string tag);
    logic [31:0] obs, exp;
    bit m;
    led_r = 8'h00;
    repeat (gap) tick();
    led_r = 8'h04; tick();
    led_r = 8'h02; tick();
    led_r = 8'h01;
    m = (m_lfsr[1:0] < miss_rate);
    exp = '0;
    if (!m) for (int k = R + 1; k <= R + H; k++) exp[k] = 1'b1;
    exp_q.push_back(exp);
    obs = '0;
    obs[0] = btn_r;
    for (int k = 1; k <= R + H + 2; k++) begin
      tick();
      obs[k] = btn_r;
    end
    if (m) exp_miss_r = sat_inc(exp_miss_r);
    else   exp_hit_r = sat_inc(exp_hit_r);
    led_r = 8'h00;
    tick(); tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s btn_window got=%h exp=%h", tag, obs, exp);
    end
    checks++;
    if (hit_r !== 8'(exp_hit_r)) begin
      failures++;
      $display("FAIL %s hit_cnt got=%0d exp=%0d", tag, hit_r, exp_hit_r);
    end
    checks++;
    if (miss_r !== 8'(exp_miss_r)) begin
      failures++;
      $display("FAIL %s miss_cnt got=%0d exp=%0d", tag, miss_r, exp_miss_r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (btn_r !== 1'b0) begin failures++; $display("FAIL reset btn got=%b exp=0", btn_r); end
    checks++; if (hit_r !== 8'd0) begin failures++; $display("FAIL reset hit got=%0d exp=0", hit_r); end
    checks++; if (miss_r !== 8'd0) begin failures++; $display("FAIL reset miss got=%0d exp=0", miss_r); end
    checks++; if (dbg_r.fsm !== WATCH) begin failures++; $display("FAIL reset state got=%0d exp=%0d", dbg_r.fsm, WATCH); end
    checks++; if (dbg_r.lfsr !== SEED) begin failures++; $display("FAIL reset lfsr got=%h exp=%h", dbg_r.lfsr, SEED); end
    checks++; if (btn_l !== 1'b0 || hit_l !== 8'd0) begin failures++; $display("FAIL reset left got=%b/%0d exp=0/0", btn_l, hit_l); end
    rst = 1'b0;
    tick();
    checks++; if (dbg_r.lfsr !== m_lfsr) begin failures++; $display("FAIL lfsr_step got=%h exp=%h", dbg_r.lfsr, m_lfsr); end
  endtask

  task automatic test_hit();
    miss_rate = 2'd0;
    arrive_r(2, "hit");
  endtask

  task automatic test_miss_rate();
    int h0, m0;
    h0 = exp_hit_r;
    m0 = exp_miss_r;
    miss_rate = 2'd3;
    for (int i = 0; i < 100; i++) arrive_r($urandom_range(1, 6), "miss_rate");
    checks++;
    if ((int'(hit_r) + int'(miss_r)) !== h0 + m0 + 100) begin
      failures++;
      $display("FAIL miss_total got=%0d exp=%0d", int'(hit_r) + int'(miss_r), h0 + m0 + 100);
    end
    checks++;
    if ((int'(miss_r) - m0) < 60 || (int'(miss_r) - m0) > 90) begin
      failures++;
      $display("FAIL miss_ratio got=%0d exp=60..90", int'(miss_r) - m0);
    end
  endtask

  task automatic test_random_rate();
    for (int i = 0; i < 30; i++) begin
      miss_rate = 2'($urandom_range(0, 3));
      arrive_r($urandom_range(1, 5), "random_rate");
    end
  endtask

  task automatic test_abort();
    int hi;
    miss_rate = 2'd0;
    hi = 0;
    led_r = 8'h04; tick();
    led_r = 8'h02; tick();
    led_r = 8'h01; tick();
    tick();
    led_r = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      if (btn_r) hi++;
      tick();
    end
    checks++; if (hi !== 0) begin failures++; $display("FAIL abort btn_cycles got=%0d exp=0", hi); end
    checks++; if (dbg_r.fsm !== WATCH) begin failures++; $display("FAIL abort state got=%0d exp=%0d", dbg_r.fsm, WATCH); end
    checks++; if (hit_r !== 8'(exp_hit_r) || miss_r !== 8'(exp_miss_r)) begin
      failures++; $display("FAIL abort counters got=%0d/%0d exp=%0d/%0d", hit_r, miss_r, exp_hit_r, exp_miss_r);
    end
    led_r = 8'h00; tick();
  endtask

  task automatic test_serve();
    logic [31:0] obs, exp;
    int hi;
    led_r = 8'hF0; tick();
    serve_r = 1'b1;
    obs = '0;
    exp = '0;
    exp[18] = 1'b1;
    exp[19] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      obs[k] = btn_r;
      tick();
    end
    serve_r = 1'b0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL serve btn_window got=%h exp=%h", obs, exp); end
    checks++; if (hit_r !== 8'(exp_hit_r)) begin failures++; $display("FAIL serve hit got=%0d exp=%0d", hit_r, exp_hit_r); end
    led_r = 8'h0F;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (btn_r) hi++;
    end
    checks++; if (hi !== 0) begin failures++; $display("FAIL no_serve btn_cycles got=%0d exp=0", hi); end
    led_r = 8'h00; tick();
  endtask

  task automatic test_left();
    logic [31:0] obs, exp;
    int hi;
    miss_rate = 2'd0;
    led_l = 8'h20; tick();
    led_l = 8'h40; tick();
    led_l = 8'h80;
    obs = '0;
    exp = '0;
    for (int k = R + 1; k <= R + H; k++) exp[k] = 1'b1;
    obs[0] = btn_l;
    for (int k = 1; k <= R + H + 2; k++) begin tick(); obs[k] = btn_l; end
    exp_hit_l = sat_inc(exp_hit_l);
    checks++; if (obs !== exp) begin failures++; $display("FAIL left btn_window got=%h exp=%h", obs, exp); end
    led_l = 8'h00; tick(); tick();
    checks++; if (hit_l !== 8'(exp_hit_l)) begin failures++; $display("FAIL left hit got=%0d exp=%0d", hit_l, exp_hit_l); end
    hi = 0;
    led_l = 8'h02; tick();
    led_l = 8'h01;
    for (int k = 0; k < 10; k++) begin tick(); if (btn_l) hi++; end
    led_l = 8'h00;
    repeat (3) tick();
    led_l = 8'h80;
    for (int k = 0; k < 10; k++) begin tick(); if (btn_l) hi++; end
    led_l = 8'h00; tick(); tick();
    checks++; if (hi !== 0) begin failures++; $display("FAIL left_wrong_end btn_cycles got=%0d exp=0", hi); end
    checks++; if (hit_l !== 8'(exp_hit_l)) begin failures++; $display("FAIL left_no_arrival hit got=%0d exp=%0d", hit_l, exp_hit_l); end
  endtask

  task automatic test_en_low();
    int hi;
    miss_rate = 2'd0;
    hi = 0;
    led_r = 8'h04; tick();
    led_r = 8'h02; tick();
    led_r = 8'h01; tick();
    tick();
    en = 1'b0; tick();
    checks++; if (dbg_r.fsm !== WATCH) begin failures++; $display("FAIL en_low state got=%0d exp=%0d", dbg_r.fsm, WATCH); end
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin tick(); if (btn_r) hi++; end
    checks++; if (hi !== 0) begin failures++; $display("FAIL en_low btn_cycles got=%0d exp=0", hi); end
    checks++; if (hit_r !== 8'(exp_hit_r)) begin failures++; $display("FAIL en_low hit got=%0d exp=%0d", hit_r, exp_hit_r); end
    checks++; if (dbg_r.lfsr !== m_lfsr) begin failures++; $display("FAIL en_low lfsr got=%h exp=%h", dbg_r.lfsr, m_lfsr); end
    led_r = 8'h00; tick();
  endtask

  task automatic test_rst_press();
    bit seen;
    miss_rate = 2'd0;
    seen = 1'b0;
    led_r = 8'h04; tick();
    led_r = 8'h02; tick();
    led_r = 8'h01;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (btn_r) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_press btn_rise got=0 exp=1"); end
    rst = 1'b1; tick();
    rst = 1'b0;
    exp_hit_r = 0; exp_miss_r = 0; exp_hit_l = 0;
    checks++; if (btn_r !== 1'b0) begin failures++; $display("FAIL rst_press btn got=%b exp=0", btn_r); end
    checks++; if (hit_r !== 8'd0 || miss_r !== 8'd0 || hit_l !== 8'd0) begin
      failures++; $display("FAIL rst_press counters got=%0d/%0d/%0d exp=0/0/0", hit_r, miss_r, hit_l);
    end
    checks++; if (dbg_r.fsm !== WATCH) begin failures++; $display("FAIL rst_press state got=%0d exp=%0d", dbg_r.fsm, WATCH); end
    led_r = 8'h00; tick(); tick();
  endtask

  task automatic test_saturate();
    miss_rate = 2'd0;
    for (int i = 0; i < 256; i++) arrive_r(1, "saturate");
    arrive_r(1, "saturate_extra");
    checks++; if (hit_r !== 8'hFF) begin failures++; $display("FAIL saturate hit got=%h exp=ff", hit_r); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; serve_r = 1'b0; serve_l = 1'b0;
    miss_rate = 2'd0; led_r = 8'h00; led_l = 8'h00;
    test_reset();
    test_hit();
    test_miss_rate();
    test_random_rate();
    test_abort();
    test_serve();
    test_left();
    test_en_low();
    test_rst_press();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
